// File: rtl/nf_xge_link_monitor.sv
`default_nettype none
// ============================================================================
// Module   : nf_xge_link_monitor
// Purpose  : Per-port 10G link-status monitor. Debounces link state, counts
//            link flaps, latches sticky faults and raises a maskable interrupt.
//            A one-cycle-latency read port snapshots and optionally clears
//            each port's registers.
// Revision : 1.0 - initial release
// ============================================================================
module nf_xge_link_monitor #(
  parameter int C_NUM_PORTS       = 4,
  parameter int C_STATUS_WIDTH    = 10,
  parameter int C_DEBOUNCE_CYCLES = 1024,
  parameter int C_CNT_WIDTH       = 16
) (
  input  logic                                  axis_aclk,
  input  logic                                  axis_aresetn,
  input  logic [C_NUM_PORTS*C_STATUS_WIDTH-1:0] status_in,
  input  logic [C_NUM_PORTS-1:0]                status_valid,
  input  logic [C_NUM_PORTS-1:0]                irq_mask,
  output logic [C_NUM_PORTS-1:0]                link_up,
  output logic                                  irq,
  input  logic                                  rd_req,
  input  logic [3:0]                            rd_port_sel,
  input  logic                                  rd_clear,
  output logic                                  rd_ack,
  output logic [C_CNT_WIDTH+4+C_STATUS_WIDTH-1:0] rd_data
);

  localparam int c_DB_W = $clog2(C_DEBOUNCE_CYCLES);
  localparam int c_RD_W = C_CNT_WIDTH + 4 + C_STATUS_WIDTH;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(C_DEBOUNCE_CYCLES - 1);

  logic [C_NUM_PORTS-1:0] w_link_up;
  logic [C_NUM_PORTS-1:0] w_pending;
  logic [c_RD_W-1:0]      w_word [C_NUM_PORTS];
  logic [c_RD_W-1:0]      w_rd_word;
  logic                   r_irq;
  logic                   r_rd_ack;
  logic [c_RD_W-1:0]      r_rd_data;

  for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
    logic [C_STATUS_WIDTH-1:0] r_latched;
    logic [c_DB_W-1:0]         r_db_cnt;
    logic                      r_link;
    logic                      r_pending;
    logic                      r_down;
    logic                      r_fault;
    logic [C_CNT_WIDTH-1:0]    r_flap;

    logic [C_STATUS_WIDTH-1:0] w_sample;
    logic                      w_raw;
    logic                      w_toggle;
    logic                      w_fall;
    logic                      w_clr;

    assign w_sample = status_in[p*C_STATUS_WIDTH +: C_STATUS_WIDTH];
    assign w_raw    = r_latched[0];
    assign w_toggle = (w_raw != r_link) && (r_db_cnt == c_DB_LAST);
    assign w_fall   = w_toggle && r_link;
    assign w_clr    = rd_req && rd_clear && (rd_port_sel == 4'(p));

    // Sample, debounce and event/sticky tracking; a same-edge event beats a clear
    always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
        r_latched <= '0;
        r_db_cnt  <= '0;
        r_link    <= 1'b0;
        r_pending <= 1'b0;
        r_down    <= 1'b0;
        r_fault   <= 1'b0;
        r_flap    <= '0;
      end else begin
        if (status_valid[p]) r_latched <= w_sample;

        if (w_raw == r_link) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
          r_db_cnt <= '0;
          r_link   <= ~r_link;
        end else begin
          r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end

        if (w_toggle)   r_pending <= 1'b1;
        else if (w_clr) r_pending <= 1'b0;

        if (w_fall)     r_down <= 1'b1;
        else if (w_clr) r_down <= 1'b0;

        if (status_valid[p] && (w_sample[8] || w_sample[9])) r_fault <= 1'b1;
        else if (w_clr)                                      r_fault <= 1'b0;

        if (w_fall) begin
          if (w_clr)              r_flap <= C_CNT_WIDTH'(1);
          else if (r_flap != '1)  r_flap <= r_flap + C_CNT_WIDTH'(1);
        end else if (w_clr) begin
          r_flap <= '0;
        end
      end
    end

    assign w_link_up[p] = r_link;
    assign w_pending[p] = r_pending;
    assign w_word[p]    = {r_flap, r_fault, r_down, r_pending, r_link, r_latched};
  end

  // Read mux; unmatched selects (out-of-range ports) return zero
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      if (rd_port_sel == 4'(i)) w_rd_word = w_word[i];
    end
  end

  // Registered interrupt and read response; rd_data holds between requests
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      r_irq     <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_irq    <= |(w_pending & irq_mask);
      r_rd_ack <= rd_req;
      if (rd_req) r_rd_data <= w_rd_word;
    end
  end

  assign link_up = w_link_up;
  assign irq     = r_irq;
  assign rd_ack  = r_rd_ack;
  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_nf_xge_link_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_nf_xge_link_monitor
// Purpose  : Directed self-checking bench for nf_xge_link_monitor
//            (4 ports, debounce 8, 4-bit flap counter).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nf_xge_link_monitor;

  localparam int NP  = 4;
  localparam int SW  = 10;
  localparam int DB  = 8;
  localparam int CW  = 4;
  localparam int RW  = CW + 4 + SW;

  logic           clk;
  logic           rstn;
  logic [NP*SW-1:0] status_in;
  logic [NP-1:0]  status_valid;
  logic [NP-1:0]  irq_mask;
  logic [NP-1:0]  link_up;
  logic           irq;
  logic           rd_req;
  logic [3:0]     rd_port_sel;
  logic           rd_clear;
  logic           rd_ack;
  logic [RW-1:0]  rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  nf_xge_link_monitor #(
    .C_NUM_PORTS(NP), .C_STATUS_WIDTH(SW),
    .C_DEBOUNCE_CYCLES(DB), .C_CNT_WIDTH(CW)
  ) dut (
    .axis_aclk(clk), .axis_aresetn(rstn),
    .status_in(status_in), .status_valid(status_valid), .irq_mask(irq_mask),
    .link_up(link_up), .irq(irq),
    .rd_req(rd_req), .rd_port_sel(rd_port_sel), .rd_clear(rd_clear),
    .rd_ack(rd_ack), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle sample strobe on port p
  task automatic set_status(input int p, input logic [SW-1:0] w);
    status_in[p*SW +: SW] = w;
    status_valid[p] = 1'b1;
    tick();
    status_valid[p] = 1'b0;
  endtask

  // Full down/up flap on port p, each phase long enough to debounce
  task automatic flap(input int p);
    set_status(p, 10'h000);
    repeat (DB) tick();
    set_status(p, 10'h001);
    repeat (DB) tick();
  endtask

  task automatic do_read(input logic [3:0] sel, input logic clr,
                         output logic [RW-1:0] d, output logic a);
    rd_req = 1'b1; rd_port_sel = sel; rd_clear = clr;
    tick();
    d = rd_data; a = rd_ack;
    rd_req = 1'b0; rd_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [RW-1:0] d;
    logic a;
    rstn = 1'b0;
    status_valid = '1;
    for (int p = 0; p < NP; p++) status_in[p*SW +: SW] = 10'h001;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (link_up !== 4'h0 || irq !== 1'b0 || rd_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: link_up=%h irq=%b rd_ack=%b, want 0/0/0", i, link_up, irq, rd_ack);
      end
    end
    rstn = 1'b1;
    tick();                      // first post-reset sample edge N
    status_valid = '0;
    for (int i = 1; i < DB; i++) begin
      tick();
      n_tests++;
      if (link_up !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_early_link edge N+%0d: link_up=%h want 0", i, link_up);
      end
    end
    tick();
    n_tests++;
    if (link_up !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_link_rise edge N+%0d: link_up=%h want f", DB, link_up);
    end
    tick();
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq_masked: irq=%b want 0", irq);
    end
    // Rising link set pending on every port; read and clear each
    for (int p = 0; p < NP; p++) begin
      do_read(4'(p), 1'b1, d, a);
      n_tests++;
      if (a !== 1'b1 || d !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h001}) begin
        n_fail++;
        $display("FAIL reset_read port%0d: ack=%b data=%h want ack=1 data=%h", p, a, d,
                 {4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h001});
      end
    end
    tick();
    n_tests++;
    if (rd_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_pulse: rd_ack=%b want 0", rd_ack);
    end
  endtask

  task automatic test_debounce();
    logic [RW-1:0] d;
    logic a;
    // 7-cycle glitch on port 1
    set_status(1, 10'h000);
    repeat (DB - 2) tick();
    set_status(1, 10'h001);
    repeat (DB + 2) tick();
    n_tests++;
    if (link_up[1] !== 1'b1 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch7_link: link_up[1]=%b irq=%b want 1/0", link_up[1], irq);
    end
    do_read(4'd1, 1'b0, d, a);
    n_tests++;
    if (d !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h001}) begin
      n_fail++;
      $display("FAIL glitch7_read: data=%h want %h", d, {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h001});
    end
    // Sustained drop on port 1 with its interrupt enabled
    irq_mask = 4'b0010;
    set_status(1, 10'h000);
    repeat (DB - 1) tick();
    n_tests++;
    if (link_up[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_early: link_up[1]=%b want 1 at N+%0d", link_up[1], DB - 1);
    end
    tick();
    n_tests++;
    if (link_up[1] !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_fall: link_up[1]=%b irq=%b want 0/0 at N+%0d", link_up[1], irq, DB);
    end
    tick();
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_irq: irq=%b want 1", irq);
    end
    irq_mask = 4'b0000;
    tick();
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_off_irq: irq=%b want 0", irq);
    end
    do_read(4'd1, 1'b0, d, a);
    n_tests++;
    if (d !== {4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000}) begin
      n_fail++;
      $display("FAIL drop_read: data=%h want %h", d, {4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000});
    end
    set_status(1, 10'h001);
    repeat (DB + 1) tick();
    do_read(4'd1, 1'b1, d, a);
  endtask

  task automatic test_saturation();
    logic [RW-1:0] d;
    logic a;
    for (int i = 0; i < 20; i++) flap(2);
    do_read(4'd2, 1'b0, d, a);
    n_tests++;
    if (d[RW-1 -: CW] !== 4'hF || d[SW] !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation: flap_cnt=%0d link=%b want 15/1", d[RW-1 -: CW], d[SW]);
    end
    do_read(4'd2, 1'b1, d, a);
  endtask

  task automatic test_clear_on_read();
    set_status(0, 10'h101);          // remote fault with block lock kept
    set_status(0, 10'h001);
    for (int i = 0; i < 3; i++) flap(0);
    irq_mask = 4'b0001;
    tick();
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL cor_irq_before: irq=%b want 1", irq);
    end
    // Back-to-back reads: clearing read then plain read
    rd_req = 1'b1; rd_port_sel = 4'd0; rd_clear = 1'b1;
    tick();
    n_tests++;
    if (rd_ack !== 1'b1 || rd_data !== {4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 10'h001} || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL cor_first: ack=%b data=%h irq=%b want 1/%h/1", rd_ack, rd_data, irq,
               {4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 10'h001});
    end
    rd_clear = 1'b0;
    tick();
    n_tests++;
    if (rd_ack !== 1'b1 || rd_data !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h001} || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL cor_second: ack=%b data=%h irq=%b want 1/%h/0", rd_ack, rd_data, irq,
               {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h001});
    end
    rd_req = 1'b0;
    tick();
    n_tests++;
    if (rd_ack !== 1'b0 || rd_data !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h001}) begin
      n_fail++;
      $display("FAIL rd_hold: ack=%b data=%h want 0/%h", rd_ack, rd_data,
               {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h001});
    end
    irq_mask = 4'b0000;
  endtask

  task automatic test_collision();
    logic [RW-1:0] d;
    logic a;
    set_status(3, 10'h000);          // edge N
    repeat (DB - 1) tick();
    rd_req = 1'b1; rd_port_sel = 4'd3; rd_clear = 1'b1;
    tick();                          // edge N+DB: link falls while clearing
    rd_req = 1'b0; rd_clear = 1'b0;
    n_tests++;
    if (link_up[3] !== 1'b0 || rd_data !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000}) begin
      n_fail++;
      $display("FAIL collide_snapshot: link_up[3]=%b data=%h want 0/%h", link_up[3], rd_data,
               {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000});
    end
    do_read(4'd3, 1'b0, d, a);
    n_tests++;
    if (d !== {4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000}) begin
      n_fail++;
      $display("FAIL collide_after: data=%h want %h", d, {4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000});
    end
  endtask

  task automatic test_fault_oor();
    logic [RW-1:0] d;
    logic a;
    set_status(2, 10'h201);          // local fault for a single sample
    set_status(2, 10'h001);
    repeat (3) tick();
    do_read(4'd2, 1'b0, d, a);
    n_tests++;
    if (d !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h001}) begin
      n_fail++;
      $display("FAIL fault_sticky: data=%h want %h", d, {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h001});
    end
    do_read(4'(NP), 1'b1, d, a);
    n_tests++;
    if (a !== 1'b1 || d !== '0) begin
      n_fail++;
      $display("FAIL oor_read: ack=%b data=%h want 1/0", a, d);
    end
    do_read(4'd2, 1'b0, d, a);
    n_tests++;
    if (d !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h001}) begin
      n_fail++;
      $display("FAIL oor_no_clear p2: data=%h want %h", d, {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h001});
    end
    do_read(4'd3, 1'b0, d, a);
    n_tests++;
    if (d !== {4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000}) begin
      n_fail++;
      $display("FAIL oor_no_clear p3: data=%h want %h", d, {4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000});
    end
  endtask

  initial begin
    rstn = 1'b0; status_in = '0; status_valid = '0; irq_mask = '0;
    rd_req = 1'b0; rd_port_sel = '0; rd_clear = 1'b0;
    test_reset();
    test_debounce();
    test_saturation();
    test_clear_on_read();
    test_collision();
    test_fault_oor();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/nf_xge_link_monitor.md
# nf_xge_link_monitor

Multi-port link-status monitor for the 10G interface subsystem, in the `axis_aclk` domain. It accepts the per-port status words already carried into the core clock by each interface block: the 8-bit PCS/PMA status plus the 2-bit MAC status. For each port it debounces the link state, counts link flaps, latches sticky fault bits and raises a maskable interrupt. A single-cycle-ack read port lets the register layer snapshot and clear each port.

## Interface
Parameters:
- `C_NUM_PORTS`, 4: number of 10G ports monitored (1–16).
- `C_STATUS_WIDTH`, 10: per-port status word; bits [7:0] are PCS/PMA status, bits [9:8] are MAC status (bit 8 remote fault, bit 9 local fault).
- `C_DEBOUNCE_CYCLES`, 1024: consecutive disagreeing cycles required to change `link_up` (≥2).
- `C_CNT_WIDTH`, 16: flap counter width.

Ports:
- `axis_aclk`, in, 1: single clock.
- `axis_aresetn`, in, 1: synchronous, active-low reset.
- `status_in`, in, C_NUM_PORTS*C_STATUS_WIDTH: port p occupies `[p*C_STATUS_WIDTH +: C_STATUS_WIDTH]`.
- `status_valid`, in, C_NUM_PORTS: per-port sample strobe.
- `irq_mask`, in, C_NUM_PORTS: 1 = interrupt enabled for that port.
- `link_up`, out, C_NUM_PORTS: debounced link state.
- `irq`, out, 1: OR of pending & mask, registered.
- `rd_req`, in, 1: single-cycle read strobe.
- `rd_port_sel`, in, 4: port to read.
- `rd_clear`, in, 1: clear-on-read qualifier, sampled with `rd_req`.
- `rd_ack`, out, 1: read-data-valid pulse.
- `rd_data`, out, C_CNT_WIDTH+4+C_STATUS_WIDTH: `{flap_cnt, sticky_fault, sticky_down, irq_pending, link_up, latched_status}`.

## Operation
- Reset (`axis_aresetn`=0 at an edge) clears all state and outputs to 0, including any debounce in progress.
- **Sampling:** when `status_valid[p]`=1, `latched_status[p]` ← the slice of `status_in` for port p. Otherwise it holds.
- The raw link for port p is `latched_status[p][0]` (PCS block lock).
- **Debounce:** each port has a counter of width clog2(C_DEBOUNCE_CYCLES).
  - While raw ≠ `link_up[p]`, the counter increments each cycle.
  - When raw = `link_up[p]`, the counter clears to 0.
  - When the counter equals C_DEBOUNCE_CYCLES-1 and raw still disagrees, `link_up[p]` toggles and the counter clears.
  - A glitch shorter than C_DEBOUNCE_CYCLES cycles never changes `link_up`.
- **Transition event:** any `link_up[p]` toggle sets `irq_pending[p]`.
  - Only a 1→0 toggle also sets `sticky_down[p]` and increments `flap_cnt[p]`.
  - `flap_cnt[p]` saturates at all-ones and does not wrap.
- **Fault:** `sticky_fault[p]` is set on any sampled word with bit 8 or bit 9 = 1.
- **Interrupt:** `irq` ← |(irq_pending & irq_mask). A mask change takes effect on `irq` on the next edge.
- **Read:**
  - On an `rd_req` edge with `rd_port_sel` < C_NUM_PORTS, `rd_data` captures that port's current registers (pre-update values) and `rd_ack`=1 for one cycle.
  - If `rd_clear`=1, that port's `flap_cnt`, `sticky_down`, `sticky_fault` and `irq_pending` clear on the same edge.
  - `link_up`, `latched_status` and the debounce counter are never cleared by a read.
- **Out-of-range port:** `rd_port_sel` ≥ C_NUM_PORTS still acks, returns `rd_data`=0 and clears nothing.
- **Simultaneous clear and event:** the event wins.
  - A sticky or pending bit set in the clearing cycle ends at 1.
  - A flap coinciding with a clear leaves `flap_cnt`=1.
  - The returned `rd_data` reflects the pre-edge state.
- `rd_data` holds its value until the next `rd_req`.

## Timing
- `status_valid` at edge N: `latched_status` is updated after edge N.
- With raw held changed, `link_up` toggles at edge N+C_DEBOUNCE_CYCLES. `irq_pending`, `sticky_down` and `flap_cnt` update on that same edge.
- `irq` follows at edge N+C_DEBOUNCE_CYCLES+1.
- Read latency is 1: `rd_req` sampled at edge M gives `rd_ack`/`rd_data` valid after edge M.
- Back-to-back `rd_req` is supported every cycle.
- No backpressure on any input.

## Test plan
- **Reset:** hold `axis_aresetn`=0 for 3 cycles with `status_valid`=all-ones and `status_in` bit0=1 → `link_up`=0, `irq`=0, `rd_ack`=0 during reset; `link_up[0]` rises exactly C_DEBOUNCE_CYCLES (set to 8) edges after the first post-reset sample.
- **Debounce:** C_DEBOUNCE_CYCLES=8, link up on port 1, raw drops for 7 cycles then recovers → `link_up[1]` stays 1 and `flap_cnt[1]`=0. A 9-cycle drop → `link_up[1]`=0, `flap_cnt[1]`=1, `irq`=1 one edge later when `irq_mask[1]`=1, and `irq`=0 when the mask is 0.
- **Saturation:** C_CNT_WIDTH=4, 20 up/down flaps on port 2 → read returns `flap_cnt`=15.
- **Clear-on-read:** port 0 with `flap_cnt`=3, sticky bits set, read with `rd_clear`=1 → `rd_data` shows 3 and the sticky bits; an immediate second read shows 0 and `irq` drops on the following edge.
- **Clear/event collision:** `rd_req`+`rd_clear` on the exact edge `link_up[3]` falls → next read shows `flap_cnt`=1, `sticky_down`=1, `irq_pending`=1.
- **Fault and out-of-range:** a sample with status bit 9=1 for one cycle on port 2 → `sticky_fault[2]`=1 persists. A read with `rd_port_sel`=C_NUM_PORTS → `rd_ack`=1, `rd_data`=0, no state changed.
